// File: rtl/bcd_seg_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_display_if
//  Description : Sample bus between the FIR output stage and the BCD display
//                stage.
//                  din       - 10-bit unsigned sample
//                  din_valid - one-cycle sample strobe
//                  busy      - high while the display stage is converting
//                The master modport is the sample producer; the slave
//                modport is the display stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_seg_display_if;
    logic [9:0] din;
    logic       din_valid;
    logic       busy;

    modport master (output din, output din_valid, input busy);
    modport slave  (input din, input din_valid, output busy);
endinterface
`default_nettype wire

// File: rtl/bcd_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_display
//  Description : Captures a 10-bit unsigned sample on a strobe, converts it
//                to four BCD digits with a sequential shift-add-3 FSM, and
//                drives a 4-digit common-anode 7-segment display through a
//                time-multiplexed scan.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                bus (slave)      - din, din_valid in; busy out
//                bcd[15:0]        - last completed result {th, hu, te, on}
//                seg[6:0]         - segments {g..a}, active-low, registered
//                an[3:0]          - digit enables, active-low, an[0] = ones
//                dp               - decimal point, active-low, always off
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bcd_seg_display_if.slave  bus,
    output logic [15:0]       bcd,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic              dp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                 c_REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_REF_W-1:0] c_REF_MAX = c_REF_W'(REFRESH_DIV - 1);

    state_t              r_state;
    state_t              w_next;
    logic [9:0]          r_shreg;
    logic [15:0]         r_scratch;
    logic [3:0]          r_count;
    logic [15:0]         r_bcd;
    logic [14:0]         w_adj;
    logic [c_REF_W-1:0]  r_refresh;
    logic [1:0]          r_index;
    logic [6:0]          r_seg;
    logic [3:0]          r_an;
    logic [3:0]          w_nib;
    logic [3:0]          w_upper_zero;
    logic                w_blank;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.din_valid) w_next = SHIFT;
            SHIFT:   if (r_count == 4'd9) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign bus.busy = (r_state != IDLE);

    // Add-3 correction for the ones, tens and hundreds nibbles. The
    // thousands nibble is at most 1 for a 10-bit input, so it never needs
    // correction and its top bit never shifts out; only its low 3 bits
    // feed the shift.
    for (genvar k = 0; k < 3; k++) begin : g_adj
        assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ?
                                 (r_scratch[4*k +: 4] + 4'd3) : r_scratch[4*k +: 4];
    end
    assign w_adj[14:12] = r_scratch[14:12];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.din_valid) begin
                        r_shreg   <= bus.din;
                        r_scratch <= '0;
                        r_count   <= '0;
                    end
                end
                SHIFT: begin
                    r_scratch <= {w_adj, r_shreg[9]};
                    r_shreg   <= {r_shreg[8:0], 1'b0};
                    r_count   <= r_count + 4'd1;
                end
                DONE: r_bcd <= r_scratch;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    assign w_nib = r_bcd[{r_index, 2'b00} +: 4];

    // w_upper_zero[k]: nibbles k..3 are all zero. Digit 0 is never blanked.
    always_comb begin
        w_upper_zero    = 4'b0000;
        w_upper_zero[3] = (r_bcd[15:12] == 4'd0);
        w_upper_zero[2] = w_upper_zero[3] && (r_bcd[11:8] == 4'd0);
        w_upper_zero[1] = w_upper_zero[2] && (r_bcd[7:4] == 4'd0);
    end

    assign w_blank = BLANK_LEAD && w_upper_zero[r_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_index   <= 2'd0;
            r_an      <= 4'b1111;
            r_seg     <= 7'b1111111;
        end else begin
            if (r_refresh == c_REF_MAX) begin
                r_refresh <= '0;
                r_index   <= r_index + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            r_an  <= w_blank ? 4'b1111    : ~(4'b0001 << r_index);
            r_seg <= w_blank ? 7'b1111111 : f_seg(w_nib);
        end
    end

    assign bcd = r_bcd;
    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_seg_display
//  Description : Self-checking bench for bcd_seg_display. Expected results
//                are queued when a sample is strobed and compared when the
//                conversion completes. dut_a blanks leading zeros, dut_b
//                does not; both scan with REFRESH_DIV = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_display;

    logic        clk;
    logic        rst;
    logic        rst_q;
    logic [15:0] bcd_a, bcd_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a,  an_b;
    logic        dp_a,  dp_b;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          busy_len;
    logic        prev_busy;

    typedef struct {
        logic [15:0] bcd;
        int          done;
    } exp_t;
    exp_t q[$];

    bcd_seg_display_if bus_a ();
    bcd_seg_display_if bus_b ();

    bcd_seg_display #(.REFRESH_DIV(4), .BLANK_LEAD(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .bcd(bcd_a), .seg(seg_a), .an(an_a), .dp(dp_a)
    );

    bcd_seg_display #(.REFRESH_DIV(4), .BLANK_LEAD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .bcd(bcd_b), .seg(seg_b), .an(an_b), .dp(dp_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int v);
        bcd_of = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: seg_of = 7'b1000000;  4'd1: seg_of = 7'b1111001;
            4'd2: seg_of = 7'b0100100;  4'd3: seg_of = 7'b0110000;
            4'd4: seg_of = 7'b0011001;  4'd5: seg_of = 7'b0010010;
            4'd6: seg_of = 7'b0000010;  4'd7: seg_of = 7'b1111000;
            4'd8: seg_of = 7'b0000000;  4'd9: seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // Completion monitor for dut_a: busy falling outside reset means a
    // result has just been written to bcd.
    initial begin
        prev_busy = 1'b0;
        busy_len  = 0;
    end
    always @(negedge clk) begin
        if (!rst_q) begin
            if (bus_a.busy) busy_len++;
            if (prev_busy && !bus_a.busy) begin
                if (q.size() == 0) begin
                    check("unexpected_conversion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("bcd_result", {16'd0, bcd_a}, {16'd0, e.bcd});
                    check("done_edge", cyc, e.done);
                    check("busy_len", busy_len, 11);
                end
            end
            if (!prev_busy && bus_a.busy && busy_len != 1) busy_len = 1;
        end else begin
            busy_len = 0;
        end
        if (!bus_a.busy) busy_len = 0;
        prev_busy = bus_a.busy;
    end

    // Called at a negedge; the strobe is sampled at the following edge.
    task automatic strobe(input logic [9:0] d);
        bus_a.din       = d;
        bus_a.din_valid = 1'b1;
        @(negedge clk);
        bus_a.din_valid = 1'b0;
    endtask

    task automatic send(input int v);
        exp_t e;
        e.bcd  = bcd_of(v);
        e.done = cyc + 12;
        q.push_back(e);
        strobe(10'(v));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 60 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) begin
            check("conversion_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [3:0] cur_an(input bit sel);
        cur_an = sel ? an_b : an_a;
    endfunction

    function automatic logic [6:0] cur_seg(input bit sel);
        cur_seg = sel ? seg_b : seg_a;
    endfunction

    // Align to the start of the ones-digit dwell, then check a full frame.
    task automatic scan_check(input bit sel, input logic [15:0] b, input bit blank_lead);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        bit         upper_zero;
        for (int t = 0; t < 20 && cur_an(sel) == 4'b1110; t++) @(negedge clk);
        for (int t = 0; t < 20 && cur_an(sel) != 4'b1110; t++) @(negedge clk);
        if (cur_an(sel) != 4'b1110) begin
            check("scan_align_timeout", {28'd0, cur_an(sel)}, 32'he);
        end else begin
            for (int i = 0; i < 16; i++) begin
                int k;
                k = i / 4;
                upper_zero = 1'b1;
                for (int j = 3; j >= 1; j--)
                    if (j >= k && b[4*j +: 4] != 4'd0) upper_zero = 1'b0;
                if (blank_lead && k != 0 && upper_zero) begin
                    exp_an  = 4'b1111;
                    exp_seg = 7'b1111111;
                end else begin
                    exp_an  = ~(4'b0001 << k);
                    exp_seg = seg_of(b[4*k +: 4]);
                end
                check("scan_an",  {28'd0, cur_an(sel)},  {28'd0, exp_an});
                check("scan_seg", {25'd0, cur_seg(sel)}, {25'd0, exp_seg});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus_a.din       = 10'h3ff;
        bus_a.din_valid = 1'b1;
        bus_b.din       = 10'd0;
        bus_b.din_valid = 1'b0;

        // Reset with din_valid held high: reset wins.
        @(negedge clk);
        check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
        check("rst_bcd",  {16'd0, bcd_a}, 32'd0);
        check("rst_an",   {28'd0, an_a}, 32'hf);
        check("rst_seg",  {25'd0, seg_a}, 32'h7f);
        check("rst_dp",   {31'd0, dp_a}, 32'd1);
        @(negedge clk);
        rst             = 1'b0;
        bus_a.din_valid = 1'b0;
        @(negedge clk);
        check("first_an",   {28'd0, an_a}, 32'he);
        check("first_seg",  {25'd0, seg_a}, {25'd0, 7'b1000000});
        check("first_busy", {31'd0, bus_a.busy}, 32'd0);

        // Main conversions with frame checks.
        send(150);
        wait_idle();
        scan_check(1'b0, 16'h0150, 1'b1);
        send(1023);
        wait_idle();
        scan_check(1'b0, 16'h1023, 1'b1);
        send(0);
        wait_idle();
        scan_check(1'b0, 16'h0000, 1'b1);
        send(9);
        wait_idle();

        // Dropped strobes at N+3 and N+11, accepted at N+12.
        send(7);
        repeat (2) @(negedge clk);
        strobe(10'd999);
        repeat (7) @(negedge clk);
        strobe(10'd999);
        send(999);
        wait_idle();
        check("after_drop_bcd", {16'd0, bcd_a}, 32'h0999);

        // Reset mid-conversion: strobe at N, reset at N+5.
        strobe(10'd512);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, bus_a.busy}, 32'd0);
        check("abort_bcd",  {16'd0, bcd_a}, 32'd0);
        repeat (20) @(negedge clk);
        check("abort_bcd_later",  {16'd0, bcd_a}, 32'd0);
        check("abort_busy_later", {31'd0, bus_a.busy}, 32'd0);
        send(512);
        wait_idle();

        // Blanking disabled on dut_b.
        bus_b.din       = 10'd7;
        bus_b.din_valid = 1'b1;
        @(negedge clk);
        bus_b.din_valid = 1'b0;
        for (int t = 0; t < 30 && bus_b.busy; t++) @(negedge clk);
        check("b_busy_done", {31'd0, bus_b.busy}, 32'd0);
        check("b_bcd", {16'd0, bcd_b}, 32'h0007);
        scan_check(1'b1, 16'h0007, 1'b0);

        repeat (2) @(negedge clk);
        check("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
